// File: rtl/dual_port_sram_128x16_if.sv
// rtl/dual_port_sram_128x16_if.sv - port A/B bus of the 128x16 dual-port SRAM
// The master drives address, data and the active-low strobes. The slave returns the registered read data.
interface dual_port_sram_128x16_if #(
  parameter int DW = 16,
  parameter int AW = 7
);
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic [DW-1:0] doutb;
  logic          enb;
  logic          web;

  modport master (
    output addra, dina, ena, wea,
    output addrb, dinb, enb, web,
    input  douta, doutb
  );

  modport slave (
    input  addra, dina, ena, wea,
    input  addrb, dinb, enb, web,
    output douta, doutb
  );
endinterface

// File: rtl/dual_port_sram_128x16.sv
// rtl/dual_port_sram_128x16.sv - true dual-port 128x16 SRAM, read-first, port A wins write collisions
// This SRAM is the storage of the 8x8 transpose double buffer. The array itself is never reset.
module dual_port_sram_128x16 #(
  parameter int DW    = 16,
  parameter int AW    = 7,
  parameter int DEPTH = 1 << AW
) (
  input  logic                    sclk,
  input  logic                    rstn,
  dual_port_sram_128x16_if.slave  bus
);

  logic [DW-1:0] mem [DEPTH];

  logic wr_a;
  logic wr_b;

  assign wr_a = !bus.ena && !bus.wea;
  assign wr_b = !bus.enb && !bus.web;

  // Port A is written last, so on a same-address double write its data is the one stored.
  always_ff @(posedge sclk) begin
    if (wr_b) mem[bus.addrb] <= bus.dinb;
    if (wr_a) mem[bus.addra] <= bus.dina;
  end

  // Any enabled access loads the old word. This makes both same-port and cross-port collisions read-first.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      bus.douta <= '0;
      bus.doutb <= '0;
    end else begin
      if (!bus.ena) bus.douta <= mem[bus.addra];
      if (!bus.enb) bus.doutb <= mem[bus.addrb];
    end
  end

endmodule

// File: tb/tb_dual_port_sram_128x16.sv
// tb/tb_dual_port_sram_128x16.sv - directed self-checking bench for dual_port_sram_128x16
module tb_dual_port_sram_128x16;

  logic sclk;
  logic rstn;
  int   checks;
  int   errors;

  dual_port_sram_128x16_if #(.DW(16), .AW(7)) bus ();

  dual_port_sram_128x16 #(.DW(16), .AW(7), .DEPTH(128)) dut (
    .sclk (sclk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.ena = 1'b1; bus.wea = 1'b1; bus.addra = '0; bus.dina = '0;
    bus.enb = 1'b1; bus.web = 1'b1; bus.addrb = '0; bus.dinb = '0;
  endtask

  initial begin
    logic [5:0] bb;
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    idle();

    // reset
    tick(); tick();
    check("reset_douta", bus.douta, 16'h0000);
    check("reset_doutb", bus.doutb, 16'h0000);
    #2 rstn = 1'b1;
    tick(); tick();
    check("idle_douta", bus.douta, 16'h0000);
    check("idle_doutb", bus.doutb, 16'h0000);

    // port A writes value = addr for 0..63
    for (int a = 0; a < 64; a++) begin
      bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = 7'(a); bus.dina = 16'(a);
      tick();
    end
    idle();

    // port B reads in transposed order
    for (int b = 0; b < 64; b++) begin
      bb = 6'(b);
      bus.enb = 1'b0; bus.web = 1'b1; bus.addrb = {1'b0, bb[2:0], bb[5:3]};
      tick();
      check("transpose_read", bus.doutb, {10'h0, bb[2:0], bb[5:3]});
    end
    idle();

    // double buffer: A fills upper half while B drains lower half
    for (int i = 0; i < 64; i++) begin
      bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = 7'(64 + i); bus.dina = 16'h1000 + 16'(64 + i);
      bus.enb = 1'b0; bus.web = 1'b1; bus.addrb = 7'(i);
      tick();
      check("dbuf_lower", bus.doutb, 16'(i));
    end
    idle();
    for (int i = 64; i < 128; i++) begin
      bus.enb = 1'b0; bus.web = 1'b1; bus.addrb = 7'(i);
      tick();
      check("dbuf_upper", bus.doutb, 16'h1000 + 16'(i));
    end
    idle();

    // collision: A write / B read same address
    bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = 7'd5; bus.dina = 16'hAAAA;
    tick();
    bus.dina = 16'h5555;
    bus.enb = 1'b0; bus.web = 1'b1; bus.addrb = 7'd5;
    tick();
    check("coll_ab_old", bus.doutb, 16'hAAAA);
    bus.ena = 1'b1;
    tick();
    check("coll_ab_new", bus.doutb, 16'h5555);
    idle();

    // collision: A read / B write same address
    bus.ena = 1'b0; bus.wea = 1'b1; bus.addra = 7'd7;
    bus.enb = 1'b0; bus.web = 1'b0; bus.addrb = 7'd7; bus.dinb = 16'h7777;
    tick();
    check("coll_ba_old", bus.douta, 16'h0007);
    bus.enb = 1'b1;
    tick();
    check("coll_ba_new", bus.douta, 16'h7777);
    idle();

    // same-port read-during-write loads the old word
    bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = 7'd6; bus.dina = 16'hBEEF;
    tick();
    check("rdw_old", bus.douta, 16'h0006);
    bus.wea = 1'b1;
    tick();
    check("rdw_new", bus.douta, 16'hBEEF);
    idle();

    // dual write: port A wins
    bus.ena = 1'b0; bus.wea = 1'b0; bus.addra = 7'd10; bus.dina = 16'h1111;
    bus.enb = 1'b0; bus.web = 1'b0; bus.addrb = 7'd10; bus.dinb = 16'h2222;
    tick();
    bus.wea = 1'b1; bus.web = 1'b1;
    tick();
    check("dual_wr_b", bus.doutb, 16'h1111);
    check("dual_wr_a", bus.douta, 16'h1111);
    idle();

    // enable gating holds doutb
    bus.enb = 1'b0; bus.web = 1'b1; bus.addrb = 7'd3;
    tick();
    check("gate_read", bus.doutb, 16'h0003);
    bus.enb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.addrb = 7'(20 + k);
      tick();
      check("gate_hold", bus.doutb, 16'h0003);
    end
    bus.ena = 1'b0; bus.wea = 1'b1; bus.addra = 7'd100;
    tick();
    idle();
    check("pre_reset_a", bus.douta, 16'h1064);

    // mid-operation reset clears outputs immediately, memory survives
    #2 rstn = 1'b0;
    #1;
    check("midreset_doutb", bus.doutb, 16'h0000);
    check("midreset_douta", bus.douta, 16'h0000);
    #2 rstn = 1'b1;
    bus.enb = 1'b0; bus.web = 1'b1; bus.addrb = 7'd3;
    tick();
    check("post_reset_mem", bus.doutb, 16'h0003);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
